// File: rtl/mdio_master_gen.sv
// mdio_master_gen: IEEE 802.3 MDIO management master (Clause 22 / Clause 45).
// Sends one 32-bit management frame onto MDC/MDIO for each accepted start
// request. An optional preamble of all-ones precedes the frame. Reads release
// MDIO from the turnaround onwards and capture 16 bits of PHY data.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   mdio_start          start request (honoured in IDLE only)
//   t_data[31:0]        {ST, OP, PHYAD/PRTAD, REGAD/DEVAD, TA, data/address}
//   no_preamble         skip the preamble for this frame
//   mdio_in             MDIO pad input
//   rd_data[15:0]       last read data
//   data_rdy            one-clk completion pulse
//   busy                frame in progress
//   ta_err              read turnaround error, held until the next accepted start
//   frame_err           one-clk pulse when a start is rejected
//   mdc, mdio_oe, mdio_out  PHY pin drivers
module mdio_master_gen #(
  parameter int CLK_DIV      = 2,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdio_start,
  input  logic [31:0] t_data,
  input  logic        no_preamble,
  input  logic        mdio_in,
  output logic [15:0] rd_data,
  output logic        data_rdy,
  output logic        busy,
  output logic        ta_err,
  output logic        frame_err,
  output logic        mdc,
  output logic        mdio_oe,
  output logic        mdio_out
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, HEADER, TA_WR, TA_RD, DATA_WR, DATA_RD, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   sh_q;        // outgoing frame, MSB is the bit on the wire
  logic          rd_q;        // latched OP[1]
  logic [5:0]    cnt_q, cnt_d; // bits remaining in current phase, minus one
  logic [DW-1:0] div_q;
  logic          arm_q;       // one-cycle gap between accept and first low half
  logic          mdc_q, oe_q, out_q, busy_q;
  logic [15:0]   shadow_q, rd_data_q;
  logic          data_rdy_q, ta_err_q, frame_err_q;
  logic          nxt_oe, nxt_out;
  logic          start_ok;

  // Clause 45 accepts any OP; Clause 22 only write (01) and read (10).
  assign start_ok = (t_data[31:30] == 2'b00) ||
                    ((t_data[31:30] == 2'b01) && (t_data[29] != t_data[28]));

  // Phase sequencing and the value of the bit that starts at the next low half.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 6'd1;
    if (cnt_q == 6'd0) begin
      case (state_q)
        PREAMBLE: begin state_d = HEADER;                 cnt_d = 6'd13; end
        HEADER:   begin state_d = rd_q ? TA_RD : TA_WR;   cnt_d = 6'd1;  end
        TA_WR:    begin state_d = DATA_WR;                cnt_d = 6'd15; end
        TA_RD:    begin state_d = DATA_RD;                cnt_d = 6'd15; end
        default:  begin state_d = DONE;                   cnt_d = 6'd0;  end
      endcase
    end
    nxt_oe = !((state_d == TA_RD) || (state_d == DATA_RD));
    if ((state_d == PREAMBLE) || !nxt_oe) nxt_out = 1'b1;
    // The shift register only advances once the preamble is over.
    else if (state_q == PREAMBLE)         nxt_out = sh_q[31];
    else                                  nxt_out = sh_q[30];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      rd_q        <= 1'b0;
      cnt_q       <= '0;
      div_q       <= '0;
      arm_q       <= 1'b0;
      mdc_q       <= 1'b0;
      oe_q        <= 1'b0;
      out_q       <= 1'b1;
      busy_q      <= 1'b0;
      shadow_q    <= '0;
      rd_data_q   <= '0;
      data_rdy_q  <= 1'b0;
      ta_err_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      data_rdy_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mdio_start) begin
            if (start_ok) begin
              sh_q     <= t_data;
              rd_q     <= t_data[29];
              ta_err_q <= 1'b0;
              arm_q    <= 1'b1;
              if (no_preamble || (PREAMBLE_LEN == 0)) begin
                state_q <= HEADER;
                cnt_q   <= 6'd13;
              end else begin
                state_q <= PREAMBLE;
                cnt_q   <= 6'(PREAMBLE_LEN - 1);
              end
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: begin
          if (arm_q) begin
            // First low half: drive the first bit, start the divider.
            arm_q  <= 1'b0;
            busy_q <= 1'b1;
            div_q  <= '0;
            mdc_q  <= 1'b0;
            oe_q   <= 1'b1;
            out_q  <= (state_q == PREAMBLE) ? 1'b1 : sh_q[31];
          end else if (div_q == DIV_LAST) begin
            div_q <= '0;
            mdc_q <= ~mdc_q;
            if (!mdc_q) begin
              // Rising MDC: sample the PHY.
              if ((state_q == TA_RD) && (cnt_q == 6'd0) && mdio_in) ta_err_q <= 1'b1;
              if (state_q == DATA_RD) shadow_q <= {shadow_q[14:0], mdio_in};
            end else begin
              // Falling MDC: bit finished, present the next one.
              cnt_q   <= cnt_d;
              state_q <= state_d;
              if (state_q != PREAMBLE) sh_q <= {sh_q[30:0], 1'b0};
              if (state_d == DONE) begin
                busy_q     <= 1'b0;
                oe_q       <= 1'b0;
                out_q      <= 1'b1;
                data_rdy_q <= 1'b1;
                if (rd_q) rd_data_q <= shadow_q;
              end else begin
                oe_q  <= nxt_oe;
                out_q <= nxt_out;
              end
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign rd_data   = rd_data_q;
  assign data_rdy  = data_rdy_q;
  assign busy      = busy_q;
  assign ta_err    = ta_err_q;
  assign frame_err = frame_err_q;
  assign mdc       = mdc_q;
  assign mdio_oe   = oe_q;
  assign mdio_out  = out_q;

endmodule

// File: tb/tb_mdio_master_gen.sv
// Bench for mdio_master_gen: a PHY responder feeds mdio_in bit by bit, a pin
// monitor records every bit presented at MDC rising, and each scenario task
// compares the recording, latency and status against a bit-list model.
module tb_mdio_master_gen;
  localparam int CD = 2;
  localparam int PL = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mdio_start = 1'b0;
  logic [31:0] t_data = '0;
  logic        no_preamble = 1'b0;
  logic        mdio_in;
  logic [15:0] rd_data;
  logic        data_rdy, busy, ta_err, frame_err, mdc, mdio_oe, mdio_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit resp[128];
  int frame_id = 0;
  int seen_id = 0;
  int nrise = 0;
  bit mdc_prev = 1'b0;
  bit cap_out[$];
  bit cap_oe[$];
  logic [15:0] exp_rd = '0;
  bit exp_ta = 1'b0;

  mdio_master_gen #(.CLK_DIV(CD), .PREAMBLE_LEN(PL)) dut (
    .clk(clk), .reset(reset), .mdio_start(mdio_start), .t_data(t_data),
    .no_preamble(no_preamble), .mdio_in(mdio_in), .rd_data(rd_data),
    .data_rdy(data_rdy), .busy(busy), .ta_err(ta_err), .frame_err(frame_err),
    .mdc(mdc), .mdio_oe(mdio_oe), .mdio_out(mdio_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pin monitor and PHY responder: bit j of the frame is driven on mdio_in
  // before the j-th MDC rise and the master's pins are recorded at each rise.
  always @(negedge clk) begin
    if (seen_id != frame_id) begin
      seen_id = frame_id;
      cap_out.delete();
      cap_oe.delete();
      nrise = 0;
      mdc_prev = 1'b0;
    end
    if (mdc && !mdc_prev) begin
      cap_out.push_back(mdio_out);
      cap_oe.push_back(mdio_oe);
      nrise++;
    end
    mdc_prev = mdc;
    mdio_in = (nrise < 128) ? resp[nrise] : 1'b1;
  end

  task automatic step;
    @(posedge clk); #2;
  endtask

  task automatic setup_frame(input logic [31:0] td, input bit np, input logic [15:0] pd, input bit ta1);
    int p;
    p = np ? 0 : PL;
    for (int i = 0; i < 128; i++) resp[i] = 1'b1;
    resp[p+15] = ta1;
    for (int i = 0; i < 16; i++) resp[p+16+i] = pd[15-i];
    frame_id++;
    mdio_start = 1'b1;
    t_data = td;
    no_preamble = np;
  endtask

  task automatic run_frame(input logic [31:0] td, input bit np, input logic [15:0] pd,
                           input bit ta1, input bit disturb, input bit pre, input bit chain);
    int p, n, k, exp_edge, nbad;
    bit rd, got, eo, ev;
    p = np ? 0 : PL;
    n = p + 32;
    rd = td[29];
    if (pre) begin
      step;
      checks++;
      if (data_rdy !== 1'b0) begin errors++; $display("FAIL done_pulse_width got=%b exp=0", data_rdy); end
    end else begin
      step;
      setup_frame(td, np, pd, ta1);
    end
    step;
    k = cyc;
    mdio_start = 1'b0;
    t_data = $urandom;
    no_preamble = 1'($urandom_range(0, 1));
    exp_ta = 1'b0;
    checks++;
    if (ta_err !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL accept_flags td=%h got ta_err=%b frame_err=%b exp 0 0", td, ta_err, frame_err);
    end
    exp_edge = k + 1 + n * 2 * CD;
    got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      step;
      if (cyc == k + 10) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid td=%h got=%b exp=1", td, busy); end
      end
      if (disturb && cyc == k + 20) begin mdio_start = 1'b1; t_data = 32'h4000_0000; end
      if (disturb && cyc == k + 21) begin
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL start_while_busy_err got=%b exp=0", frame_err); end
      end
      if (disturb && cyc == k + 22) mdio_start = 1'b0;
      if (data_rdy === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL done_timeout td=%h got no data_rdy exp edge %0d", td, exp_edge);
    end else begin
      if (rd) exp_rd = pd;
      exp_ta = rd && ta1;
      checks++;
      if (cyc != exp_edge) begin errors++; $display("FAIL latency td=%h got=%0d exp=%0d", td, cyc - k, exp_edge - k); end
      checks++;
      if (rd_data !== exp_rd) begin errors++; $display("FAIL rd_data td=%h got=%h exp=%h", td, rd_data, exp_rd); end
      checks++;
      if (ta_err !== exp_ta) begin errors++; $display("FAIL ta_err td=%h got=%b exp=%b", td, ta_err, exp_ta); end
      checks++;
      if ({busy, mdc, mdio_oe, mdio_out} !== 4'b0001) begin
        errors++; $display("FAIL done_pins td=%h got busy/mdc/oe/out=%b exp=0001", td, {busy, mdc, mdio_oe, mdio_out});
      end
      checks++;
      if (cap_out.size() != n) begin
        errors++; $display("FAIL bit_count td=%h got=%0d exp=%0d", td, cap_out.size(), n);
      end else begin
        nbad = 0;
        for (int i = 0; i < n; i++) begin
          if (i < p) begin eo = 1'b1; ev = 1'b1; end
          else if (rd && (i - p) >= 14) begin eo = 1'b0; ev = 1'b1; end
          else begin eo = 1'b1; ev = td[31-(i-p)]; end
          if (cap_out[i] !== ev || cap_oe[i] !== eo) nbad++;
        end
        checks++;
        if (nbad != 0) begin errors++; $display("FAIL frame_bits td=%h got %0d bad bits exp 0", td, nbad); end
      end
    end
    if (!chain) begin
      step;
      checks++;
      if (data_rdy !== 1'b0) begin errors++; $display("FAIL done_pulse_width got=%b exp=0", data_rdy); end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) step;
    checks++;
    if ({mdc, mdio_oe, mdio_out, busy, data_rdy, ta_err, frame_err} !== 7'b0010000 || rd_data !== 16'h0) begin
      errors++; $display("FAIL reset_values got=%b rd=%h exp=0010000 rd=0000",
                         {mdc, mdio_oe, mdio_out, busy, data_rdy, ta_err, frame_err}, rd_data);
    end
    reset = 1'b0;
    repeat (4) step;
    checks++;
    if (mdc !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_mdc got mdc=%b busy=%b exp 0 0", mdc, busy); end
  endtask

  task automatic test_c22_write;
    run_frame(32'h5F8A_1234, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_c22_read;
    run_frame(32'h6F8A_0000, 1'b0, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_c45_addr;
    run_frame(32'h0346_ABCD, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_invalid;
    logic [31:0] bad [3];
    bad[0] = 32'h4000_0000;
    bad[1] = 32'h7000_0000;
    bad[2] = $urandom;
    bad[2][31] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      mdio_start = 1'b1;
      t_data = bad[i];
      no_preamble = 1'($urandom_range(0, 1));
      step;
      mdio_start = 1'b0;
      checks++;
      if (frame_err !== 1'b1 || busy !== 1'b0 || mdc !== 1'b0 || ta_err !== exp_ta) begin
        errors++; $display("FAIL reject td=%h got err/busy/mdc/ta=%b%b%b%b exp=100%b",
                           bad[i], frame_err, busy, mdc, ta_err, exp_ta);
      end
      step;
      checks++;
      if (frame_err !== 1'b0 || busy !== 1'b0 || mdio_oe !== 1'b0) begin
        errors++; $display("FAIL reject_after td=%h got err/busy/oe=%b%b%b exp=000", bad[i], frame_err, busy, mdio_oe);
      end
    end
  endtask

  task automatic test_ta_error;
    // Clause 45 read-increment; PHY answers 1 on the second TA bit.
    run_frame(32'h2346_0000, 1'b0, 16'h5A3C, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step;
    checks++;
    if (ta_err !== 1'b1) begin errors++; $display("FAIL ta_err_hold got=%b exp=1", ta_err); end
    test_invalid;
    // The accept check inside run_frame covers the clear.
    run_frame(32'h5000_FFFF, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_frame(32'h6C21_0000, 1'b1, 16'h1357, 1'b0, 1'b0, 1'b0, 1'b1);
    setup_frame(32'h5C22_9ABC, 1'b1, 16'h0, 1'b0);
    run_frame(32'h5C22_9ABC, 1'b1, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random;
    logic [31:0] td;
    logic [1:0]  st, op;
    for (int i = 0; i < 6; i++) begin
      st = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00;
      if (st == 2'b01) op = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
      else             op = 2'($urandom_range(0, 3));
      td = $urandom;
      td[31:30] = st;
      td[29:28] = op;
      run_frame(td, 1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid;
    run_frame(32'h6F8A_0000, 1'b1, 16'hC0DE, 1'b0, 1'b0, 1'b0, 1'b0);
    step;
    setup_frame(32'h5F8A_1234, 1'b0, 16'h0, 1'b0);
    step;
    mdio_start = 1'b0;
    repeat ((PL + 5) * 2 * CD) step;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_before_reset got=%b exp=1", busy); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({mdc, mdio_oe, mdio_out, busy, data_rdy, ta_err, frame_err} !== 7'b0010000 || rd_data !== 16'h0) begin
      errors++; $display("FAIL reset_mid got=%b rd=%h exp=0010000 rd=0000",
                         {mdc, mdio_oe, mdio_out, busy, data_rdy, ta_err, frame_err}, rd_data);
    end
    exp_rd = '0;
    exp_ta = 1'b0;
    step;
    step;
    reset = 1'b0;
    step;
    checks++;
    if (busy !== 1'b0 || mdc !== 1'b0) begin errors++; $display("FAIL no_resume got busy=%b mdc=%b exp 0 0", busy, mdc); end
    run_frame(32'h5F8A_1234, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_c22_write;
    test_c22_read;
    test_c45_addr;
    test_ta_error;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
